dmem_responder: RTL and testbench

- Data-memory responder for the processor's data port; the target end of the DM_* interface the datapath drives.
- Latches each read or write request and serves it after a configurable number of wait states.
- Returns read data with a one-cycle ready pulse.
- Flags illegal accesses (misaligned, out of range, read+write together) with a 4-bit status code sized to feed the exception path's EStatus input.

---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory port between the datapath (master) and the responder (slave).
// Request fields flow master->slave; completion/status flow back.
interface dmem_responder_if #(
  parameter int N = 64
);
  logic [N-1:0] DM_addr;
  logic [N-1:0] DM_writeData;
  logic         DM_writeEnable;
  logic         DM_readEnable;
  logic [N-1:0] DM_readData;
  logic         DM_ready;
  logic         DM_busy;
  logic         DM_err;
  logic [3:0]   DM_errCode;

  modport master (
    output DM_addr, DM_writeData,
    output DM_writeEnable, DM_readEnable,
    input  DM_readData, DM_ready,
    input  DM_busy, DM_err, DM_errCode
  );

  modport slave (
    input  DM_addr, DM_writeData,
    input  DM_writeEnable, DM_readEnable,
    output DM_readData, DM_ready,
    output DM_busy, DM_err, DM_errCode
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: latches one request, serves it
// LATENCY+1 edges later, flags illegal accesses with an EStatus code.
module dmem_responder #(
  parameter int N       = 64,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input logic         clk,
  input logic         reset,
  dmem_responder_if.slave dm
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N-4:0] DEPTH_W = (N-3)'(DEPTH);
  localparam logic [2:0] LAT_W = 3'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [N-1:0] addr_q, wdata_q;
  logic         we_q, re_q;
  logic [N-1:0] rdata_q;
  logic         ready_q, err_q;
  logic [3:0]   code_q, ecode;
  logic         accept;
  logic [IW-1:0] idx;
  logic [N-1:0] mem [DEPTH];

  assign accept = (state_q == IDLE) &&
                  (dm.DM_writeEnable || dm.DM_readEnable);
  assign idx    = addr_q[3 +: IW];

  // Checks are prioritised, so an if-chain rather than a parallel case.
  always_comb begin
    ecode = 4'b0000;
    if (we_q && re_q)
      ecode = 4'b0011;
    else if (addr_q[2:0] != 3'b000)
      ecode = 4'b0100;
    else if (addr_q[N-1:3] >= DEPTH_W)
      ecode = 4'b0101;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_W;
          state_d = (LAT_W != 3'd0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= dm.DM_addr;
        wdata_q <= dm.DM_writeData;
        we_q    <= dm.DM_writeEnable;
        re_q    <= dm.DM_readEnable;
      end
    end
  end

  // Completion is registered on the edge leaving RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 4'b0000;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 4'b0000;
      if (state_q == RESP) begin
        ready_q <= 1'b1;
        if (ecode != 4'b0000) begin
          err_q  <= 1'b1;
          code_q <= ecode;
        end else if (we_q) begin
          mem[idx] <= wdata_q;
        end else begin
          rdata_q <= mem[idx];
        end
      end
    end
  end

  assign dm.DM_readData = rdata_q;
  assign dm.DM_ready    = ready_q;
  assign dm.DM_busy     = (state_q == WAIT);
  assign dm.DM_err      = err_q;
  assign dm.DM_errCode  = code_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=2 instance for function/legality/reset,
// LATENCY=0 instance for minimum-latency and back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if #(.N(64)) i2 ();
  dmem_responder_if #(.N(64)) i0 ();

  dmem_responder #(.N(64), .DEPTH(32), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .dm(i2.slave)
  );
  dmem_responder #(.N(64), .DEPTH(32), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .dm(i0.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue on LATENCY=2 port; returns at the negedge after the ready edge.
  // glitch drives a bogus write during WAIT that must be ignored.
  task automatic req2(input logic we, input logic re,
                      input logic [63:0] a, input logic [63:0] d,
                      input logic glitch);
    @(negedge clk);
    i2.DM_writeEnable = we;
    i2.DM_readEnable  = re;
    i2.DM_addr        = a;
    i2.DM_writeData   = d;
    @(negedge clk);
    i2.DM_writeEnable = 1'b0;
    i2.DM_readEnable  = 1'b0;
    chk("busy_t0", 64'(i2.DM_busy), 64'd1);
    chk("ready_t0", 64'(i2.DM_ready), 64'd0);
    if (glitch) begin
      i2.DM_addr        = 64'h20;
      i2.DM_writeData   = 64'hBAD0_BAD0_BAD0_BAD0;
      i2.DM_writeEnable = 1'b1;
    end
    @(negedge clk);
    chk("busy_t1", 64'(i2.DM_busy), 64'd1);
    @(negedge clk);
    i2.DM_writeEnable = 1'b0;
    chk("busy_t2", 64'(i2.DM_busy), 64'd0);
    chk("ready_t2", 64'(i2.DM_ready), 64'd0);
    @(negedge clk);
    chk("ready_t3", 64'(i2.DM_ready), 64'd1);
    chk("busy_t3", 64'(i2.DM_busy), 64'd0);
  endtask

  initial begin
    i2.DM_addr = '0; i2.DM_writeData = '0;
    i2.DM_writeEnable = 1'b0; i2.DM_readEnable = 1'b0;
    i0.DM_addr = '0; i0.DM_writeData = '0;
    i0.DM_writeEnable = 1'b0; i0.DM_readEnable = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rdata", i2.DM_readData, 64'd0);
    chk("rst_ready", 64'(i2.DM_ready), 64'd0);
    chk("rst_busy", 64'(i2.DM_busy), 64'd0);
    chk("rst_err", 64'(i2.DM_err), 64'd0);
    chk("rst_code", 64'(i2.DM_errCode), 64'd0);
    reset = 1'b1;

    req2(1'b1, 1'b0, 64'h10, 64'hDEAD_BEEF_0000_0001, 1'b0);
    chk("wr10_err", 64'(i2.DM_err), 64'd0);
    req2(1'b0, 1'b1, 64'h10, 64'h0, 1'b0);
    chk("rd10_data", i2.DM_readData, 64'hDEAD_BEEF_0000_0001);
    chk("rd10_err", 64'(i2.DM_err), 64'd0);
    @(negedge clk);
    chk("code_clear", 64'(i2.DM_errCode), 64'd0);

    req2(1'b0, 1'b1, 64'h0C, 64'h0, 1'b0);
    chk("mis_err", 64'(i2.DM_err), 64'd1);
    chk("mis_code", 64'(i2.DM_errCode), 64'h4);
    chk("mis_rdata", i2.DM_readData, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    chk("mis_err_drop", 64'(i2.DM_err), 64'd0);
    chk("mis_code_drop", 64'(i2.DM_errCode), 64'd0);

    req2(1'b1, 1'b0, 64'h08, 64'h1111_2222_3333_4444, 1'b0);
    req2(1'b1, 1'b1, 64'h08, 64'h5555_6666_7777_8888, 1'b0);
    chk("both_err", 64'(i2.DM_err), 64'd1);
    chk("both_code", 64'(i2.DM_errCode), 64'h3);
    req2(1'b0, 1'b1, 64'h08, 64'h0, 1'b0);
    chk("rd08_data", i2.DM_readData, 64'h1111_2222_3333_4444);

    req2(1'b1, 1'b0, 64'h100, 64'hFFFF_0000_FFFF_0000, 1'b0);
    chk("oor_code", 64'(i2.DM_errCode), 64'h5);
    req2(1'b1, 1'b0, 64'h8000_0000_0000_0010, 64'hABCD, 1'b0);
    chk("oor_hi_code", 64'(i2.DM_errCode), 64'h5);
    req2(1'b0, 1'b1, 64'h0, 64'h0, 1'b0);
    chk("rd00_data", i2.DM_readData, 64'd0);
    req2(1'b0, 1'b1, 64'h10, 64'h0, 1'b0);
    chk("rd10_nowrap", i2.DM_readData, 64'hDEAD_BEEF_0000_0001);

    req2(1'b0, 1'b1, 64'h10, 64'h0, 1'b1);
    chk("glitch_rdata", i2.DM_readData, 64'hDEAD_BEEF_0000_0001);
    chk("glitch_err", 64'(i2.DM_err), 64'd0);
    req2(1'b0, 1'b1, 64'h20, 64'h0, 1'b0);
    chk("rd20_data", i2.DM_readData, 64'd0);

    req2(1'b1, 1'b0, 64'hF8, 64'h0123_4567_89AB_CDEF, 1'b0);
    chk("wrF8_err", 64'(i2.DM_err), 64'd0);
    req2(1'b0, 1'b1, 64'hF8, 64'h0, 1'b0);
    chk("rdF8_data", i2.DM_readData, 64'h0123_4567_89AB_CDEF);
    chk("rdF8_err", 64'(i2.DM_err), 64'd0);

    @(negedge clk);
    i2.DM_writeEnable = 1'b1;
    i2.DM_addr        = 64'h18;
    i2.DM_writeData   = 64'h7777_0000_7777_0000;
    @(negedge clk);
    i2.DM_writeEnable = 1'b0;
    chk("arst_busy_pre", 64'(i2.DM_busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_rdata", i2.DM_readData, 64'd0);
    chk("arst_busy", 64'(i2.DM_busy), 64'd0);
    chk("arst_ready", 64'(i2.DM_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    req2(1'b0, 1'b1, 64'h18, 64'h0, 1'b0);
    chk("rd18_after_rst", i2.DM_readData, 64'd0);
    req2(1'b0, 1'b1, 64'hF8, 64'h0, 1'b0);
    chk("rdF8_cleared", i2.DM_readData, 64'd0);

    @(negedge clk);
    i0.DM_writeEnable = 1'b1;
    i0.DM_addr        = 64'h08;
    i0.DM_writeData   = 64'h0A0B_0C0D_0E0F_1011;
    @(negedge clk);
    chk("l0_ready_t0", 64'(i0.DM_ready), 64'd0);
    chk("l0_busy_t0", 64'(i0.DM_busy), 64'd0);
    i0.DM_writeEnable = 1'b0;
    i0.DM_readEnable  = 1'b1;
    @(negedge clk);
    chk("l0_ready_t1", 64'(i0.DM_ready), 64'd1);
    chk("l0_busy_t1", 64'(i0.DM_busy), 64'd0);
    @(negedge clk);
    chk("l0_ready_t2", 64'(i0.DM_ready), 64'd0);
    chk("l0_busy_t2", 64'(i0.DM_busy), 64'd0);
    @(negedge clk);
    chk("l0_ready_t3", 64'(i0.DM_ready), 64'd1);
    chk("l0_rdata", i0.DM_readData, 64'h0A0B_0C0D_0E0F_1011);
    @(negedge clk);
    chk("l0_ready_t4", 64'(i0.DM_ready), 64'd0);
    chk("l0_busy_t4", 64'(i0.DM_busy), 64'd0);
    @(negedge clk);
    chk("l0_ready_t5", 64'(i0.DM_ready), 64'd1);
    chk("l0_err_t5", 64'(i0.DM_err), 64'd0);
    i0.DM_readEnable = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
